capture_buffer: RTL

- Parametrised sample memory between the sampler/trigger path and the UART transmit mux.
- Once armed, it records valid samples into a circular RAM. A trigger (run) starts a post-trigger countdown. The block then streams the stored samples out, newest first, over a valid/ready handshake.
- Generalises the single-sample pass-through path: configurable width and depth, pre/post-trigger split, and backpressure.

---
 rtl/capture_buffer_pkg.sv | 17 +
 rtl/capture_buffer_if.sv | 30 +++
 rtl/capture_buffer_ram.sv | 21 ++
 rtl/capture_buffer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/capture_buffer_pkg.sv
// Shared types and helpers for the capture buffer: FSM state encoding and counter width.
package capture_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    POST  = 3'd2,
    FETCH = 3'd3,
    DUMP  = 3'd4
  } cb_state_t;

  // Wide enough to hold DEPTH itself, not just DEPTH-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/capture_buffer_if.sv
// Control, sample input and valid/ready output bundle of the capture buffer.
// The master drives commands, samples and out_ready; the slave returns the dumped samples and status.
interface capture_buffer_if #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int CNT_W        = 11
);
  logic                    arm;
  logic                    abort;
  logic                    run;
  logic                    valid_in;
  logic [SAMPLE_WIDTH-1:0] data_in;
  logic [CNT_W-1:0]        read_count;
  logic [CNT_W-1:0]        delay_count;
  logic [SAMPLE_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    triggered;
  logic                    done;

  modport master (
    output arm, abort, run, valid_in, data_in, read_count, delay_count, out_ready,
    input  out_data, out_valid, busy, triggered, done
  );

  modport slave (
    input  arm, abort, run, valid_in, data_in, read_count, delay_count, out_ready,
    output out_data, out_valid, busy, triggered, done
  );
endinterface

// File: rtl/capture_buffer_ram.sv
// Simple dual-port sample RAM: one write port and one synchronous read port, no reset.
// Read data appears the cycle after i_re and holds until the next read is issued.
module capbuf_ram #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 1024
) (
  input  logic                       clock,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [SAMPLE_WIDTH-1:0]    i_wdata,
  input  logic                       i_re,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [SAMPLE_WIDTH-1:0]    o_rdata
);
  logic [SAMPLE_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/capture_buffer.sv
// Circular pre/post-trigger sample capture, dumped newest-first over valid/ready at one sample per cycle.
// Output holds while out_ready is low; CAPTURE_BUFFER_STATUS_EN adds fill_level and overwrite outputs.
module capture_buffer
  import capture_buffer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 1024,
  parameter int CNT_W        = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef CAPTURE_BUFFER_STATUS_EN
  output logic [CNT_W-1:0] fill_level,
  output logic             overwrite,
`endif
  capture_buffer_if.slave  bus
);
  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  cb_state_t               r_state, w_next;
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr, w_rd_addr;
  logic [CNT_W-1:0]        r_stored, r_read_lat, r_delay_lat, r_post_cnt, r_remaining, w_avail;
  logic                    r_out_valid, r_triggered, r_done;
  logic                    w_start, w_trig, w_we, w_fetch, w_accept, w_last, w_re;
  logic [SAMPLE_WIDTH-1:0] w_rdata;

  function automatic logic [CNT_W-1:0] clamp_depth(input logic [CNT_W-1:0] v);
    return (v > DEPTH_C) ? DEPTH_C : v;
  endfunction

  // abort gates every qualified event so it overrides all other activity
  assign w_avail   = (r_read_lat < r_stored) ? r_read_lat : r_stored;
  assign w_start   = !bus.abort && (r_state == IDLE) && bus.arm;
  assign w_trig    = !bus.abort && (r_state == ARMED) && bus.run;
  assign w_we      = !bus.abort && bus.valid_in &&
                     ((r_state == ARMED) || ((r_state == POST) && (r_post_cnt != '0)));
  assign w_fetch   = !bus.abort && (r_state == FETCH);
  assign w_accept  = !bus.abort && (r_state == DUMP) && r_out_valid && bus.out_ready;
  assign w_last    = w_accept && (r_remaining == CNT_W'(1));
  assign w_re      = (w_fetch && (w_avail != '0)) || (w_accept && !w_last);
  assign w_rd_addr = w_fetch ? (r_wr_ptr - AW'(1)) : (r_rd_ptr - AW'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.arm) w_next = ARMED;
        ARMED:   if (bus.run) w_next = POST;
        POST:    if ((r_post_cnt == '0) || (w_we && (r_post_cnt == CNT_W'(1)))) w_next = FETCH;
        FETCH:   w_next = (w_avail == '0) ? IDLE : DUMP;
        DUMP:    if (w_last) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (r_state == ARMED) || (r_state == POST) || (r_state == DUMP);
    bus.out_valid = r_out_valid;
    bus.out_data  = r_out_valid ? w_rdata : '0;
    bus.triggered = r_triggered;
    bus.done      = r_done;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_stored    <= '0;
      r_read_lat  <= '0;
      r_delay_lat <= '0;
      r_post_cnt  <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_start) begin
        r_wr_ptr    <= '0;
        r_stored    <= '0;
        r_read_lat  <= clamp_depth(bus.read_count);
        r_delay_lat <= clamp_depth(bus.delay_count);
      end
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_stored != DEPTH_C) r_stored <= r_stored + CNT_W'(1);
      end
      // A sample coinciding with run is still pre-trigger, so the countdown loads untouched
      if (w_trig)                         r_post_cnt <= r_delay_lat;
      else if (w_we && (r_state == POST)) r_post_cnt <= r_post_cnt - CNT_W'(1);
      if (w_fetch) begin
        r_rd_ptr    <= r_wr_ptr - AW'(1);
        r_remaining <= w_avail;
      end else if (w_accept) begin
        r_rd_ptr    <= r_rd_ptr - AW'(1);
        r_remaining <= r_remaining - CNT_W'(1);
      end
      r_out_valid <= (w_next == DUMP);
      r_triggered <= (w_next == POST) || (w_next == FETCH) || (w_next == DUMP);
      r_done      <= (w_fetch && (w_avail == '0)) || w_last;
    end
  end

`ifdef CAPTURE_BUFFER_STATUS_EN
  logic r_overwrite;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           r_overwrite <= 1'b0;
    else if (w_start)                       r_overwrite <= 1'b0;
    else if (w_we && (r_stored == DEPTH_C)) r_overwrite <= 1'b1;
  end

  assign fill_level = r_stored;
  assign overwrite  = r_overwrite;
`endif

  capbuf_ram #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .DEPTH        (DEPTH)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_re    (w_re),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );
endmodule
